// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine: FSM states, mode encoding
// and the width of the binary-mode common-power-of-two counter.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

    // k counts shared factors of two, which is at most WIDTH-1
    function automatic int k_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_if.sv
// Operand/result handshake bundle for gcd_unit. The master drives operands and
// consumes results; the slave is the engine.
interface gcd_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             mode_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_out;
    logic [CNT_W-1:0] iter_out;
    logic             busy;

    modport master (
        output in_valid, a_in, b_in, mode_in, out_ready,
        input  in_ready, out_valid, gcd_out, iter_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, mode_in, out_ready,
        output in_ready, out_valid, gcd_out, iter_out, busy
    );
endinterface

// File: rtl/gcd_datapath.sv
// Operand registers and single-step reduction logic for subtraction and
// binary (Stein) GCD; the controller decides when to load and when to step.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K_W   = k_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             mode_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             eq,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [K_W-1:0]   k_q;
    logic             mode_q;
    logic             gt;
    logic             a_even;
    logic             b_even;

    assign eq     = (a_q == b_q);
    assign gt     = (a_q > b_q);
    assign a_even = ~a_q[0];
    assign b_even = ~b_q[0];

    // Binary mode restores the stripped common power of two on exit
    assign result = (mode_q == MODE_BIN) ? (a_q << k_q) : a_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others in the same step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            mode_q <= MODE_SUB;
        end else if (load) begin
            a_q    <= a_in;
            b_q    <= b_in;
            k_q    <= '0;
            mode_q <= mode_in;
        end else if (step && !eq) begin
            if (mode_q == MODE_SUB) begin
                if (gt) a_q <= a_q - b_q;
                else    b_q <= b_q - a_q;
            end else if (a_even && b_even) begin
                a_q <= a_q >> 1;
                b_q <= b_q >> 1;
                k_q <= k_q + 1'b1;
            end else if (a_even) begin
                a_q <= a_q >> 1;
            end else if (b_even) begin
                b_q <= b_q >> 1;
            end else if (gt) begin
                a_q <= (a_q - b_q) >> 1;
            end else begin
                b_q <= (b_q - a_q) >> 1;
            end
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// GCD engine top: IDLE/CALC/DONE controller, saturating iteration counter and
// result register around the reduction datapath.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    gcd_if.slave bus
);
    localparam int K_W = k_width(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] gcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             zero_op;
    logic             eq;
    logic [WIDTH-1:0] result;

    assign accept  = (state_q == ST_IDLE) && bus.in_valid;
    assign zero_op = (bus.a_in == '0) || (bus.b_in == '0);

    gcd_datapath #(
        .WIDTH (WIDTH),
        .K_W   (K_W)
    ) u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .step    (state_q == ST_CALC),
        .mode_in (bus.mode_in),
        .a_in    (bus.a_in),
        .b_in    (bus.b_in),
        .eq      (eq),
        .result  (result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        cnt_q <= '0;
                        if (zero_op) begin
                            gcd_q   <= bus.a_in | bus.b_in;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
                    if (eq) begin
                        gcd_q   <= result;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.gcd_out   = gcd_q;
    assign bus.iter_out  = cnt_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: directed cases, backpressure, reset abort,
// counter saturation and randomized pairs against a Euclid-based model.
module tb_gcd_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    gcd_if #(.WIDTH(16), .CNT_W(16)) bus ();
    gcd_if #(.WIDTH(16), .CNT_W(4))  bus4 ();

    gcd_unit #(.WIDTH(16), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    gcd_unit #(.WIDTH(16), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned euclid(input int unsigned a, input int unsigned b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Subtraction mode: one cycle per unit of each Euclid quotient (the final
    // quotient's last unit is the equality cycle). Binary mode: apply Stein's rules.
    function automatic int unsigned ref_iters(input int unsigned a, input int unsigned b, input bit m);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        int unsigned n = 0;
        if (a == 0 || b == 0) return 0;
        if (!m) begin
            while (y != 0) begin
                n += x / y;
                t = x % y;
                x = y;
                y = t;
            end
        end else begin
            while (x != y) begin
                if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; end
                else if (x % 2 == 0) x /= 2;
                else if (y % 2 == 0) y /= 2;
                else if (x > y) x = (x - y) / 2;
                else y = (y - x) / 2;
                n++;
            end
            n++;
        end
        return n;
    endfunction

    task automatic do_txn(input int unsigned a, input int unsigned b, input bit m,
                          input int hold, input int budget);
        int unsigned exp_g;
        int unsigned exp_it;
        int n;
        logic [15:0] held;
        exp_g  = (a == 0 || b == 0) ? (a | b) : euclid(a, b);
        exp_it = ref_iters(a, b, m);
        n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.a_in = a[15:0];
        bus.b_in = b[15:0];
        bus.mode_in = m;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a_in = 16'($urandom);
        bus.b_in = 16'($urandom);
        n = 0;
        while (!bus.out_valid && n < budget) begin @(posedge clk); #1; n++; end
        check("latency", n, exp_it);
        check("gcd_out", bus.gcd_out, exp_g);
        check("iter_out", bus.iter_out, exp_it);
        check("busy_in_done", bus.busy, 1);
        check("in_ready_in_done", bus.in_ready, 0);
        held = bus.gcd_out;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a_in = 16'($urandom_range(1, 500));
            bus.b_in = 16'($urandom_range(1, 500));
            @(posedge clk); #1;
            check("bp_gcd_stable", bus.gcd_out, held);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_pop", bus.out_valid, 0);
        check("in_ready_after_pop", bus.in_ready, 1);
    endtask

    initial begin
        int n;
        int unsigned ra;
        int unsigned rb;
        bit rm;

        bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.mode_in = 1'b0; bus.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.a_in = '0; bus4.b_in = '0; bus4.mode_in = 1'b0; bus4.out_ready = 1'b0;

        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_gcd_out", bus.gcd_out, 0);
        check("rst_iter_out", bus.iter_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_txn(143, 78, 1'b0, 0, 100);
        do_txn(48, 18, 1'b1, 0, 100);
        do_txn(143, 78, 1'b1, 0, 100);
        do_txn(0, 35, 1'b0, 0, 100);
        do_txn(0, 0, 1'b1, 0, 100);
        do_txn(35, 0, 1'b1, 0, 100);
        do_txn(143, 78, 1'b0, 10, 100);
        do_txn(84, 36, 1'b1, 0, 100);
        do_txn(16'hFFFF, 16'hFFFF, 1'b0, 0, 100);
        do_txn(32768, 16384, 1'b1, 0, 100);

        // Abort a long subtraction run with an asynchronous reset
        bus.a_in = 16'hFFFF; bus.b_in = 16'd1; bus.mode_in = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        check("pre_abort_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_gcd_out", bus.gcd_out, 0);
        check("abort_iter_out", bus.iter_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn(100, 75, 1'b0, 0, 100);

        // Narrow counter saturates while the result stays correct
        bus4.a_in = 16'd200; bus4.b_in = 16'd1; bus4.mode_in = 1'b0; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        n = 0;
        while (!bus4.out_valid && n < 400) begin @(posedge clk); #1; n++; end
        check("sat_latency", n, 200);
        check("sat_iter_out", bus4.iter_out, 15);
        check("sat_gcd_out", bus4.gcd_out, 1);
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        check("sat_in_ready_after_pop", bus4.in_ready, 1);

        for (int i = 0; i < 24; i++) begin
            rm = 1'($urandom);
            if (rm) begin
                ra = $urandom & 32'hFFFF;
                rb = $urandom & 32'hFFFF;
            end else begin
                ra = $urandom_range(0, 400);
                rb = $urandom_range(0, 400);
            end
            if (i % 8 == 7) ra = 0;
            do_txn(ra, rb, rm, 0, 1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gcd_unit.md
# gcd_unit

Parametrised greatest-common-divisor engine; successor to the fixed 16-bit subtract-only GCD datapath/controller pair. Accepts both operands in one valid/ready transfer and selects per transaction between repeated subtraction and binary (Stein) iteration. Returns the result with an iteration count over a valid/ready output port. It sits behind any producer of operand pairs (bus slave, test sequencer) and holds one transaction at a time.

## Interface
- `WIDTH`, 16: operand and result width in bits (≥ 2).
- `CNT_W`, 16: width of the iteration counter (≥ 4).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: engine can accept; high only in IDLE.
- `a_in` in WIDTH: operand A.
- `b_in` in WIDTH: operand B.
- `mode_in` in 1: 0 = subtraction, 1 = binary (Stein); sampled with the operands.
- `out_valid` out 1: result available; high only in DONE.
- `out_ready` in 1: consumer takes result.
- `gcd_out` out WIDTH: result; stable while `out_valid` is high.
- `iter_out` out CNT_W: number of CALC cycles used; saturates at all-ones.
- `busy` out 1: high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE. Reset state IDLE. Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `gcd_out`=0, `iter_out`=0, internal A, B and shift count k = 0.
- IDLE: on `in_valid & in_ready`, latch A, B and mode; clear k and the counter.
  - If A=0 or B=0: go directly to DONE with result A|B, so gcd(0,0)=0; `iter_out`=0.
  - Otherwise go to CALC.
- Each CALC cycle increments the counter (saturating), then performs one step.
- Subtraction mode:
  - A>B: A←A−B.
  - B>A: B←B−A.
  - A=B: result←A, go to DONE.
- Binary mode, first matching rule applies:
  - A=B: result←A<<k (truncated to WIDTH), go to DONE.
  - Both even: A←A>>1, B←B>>1, k←k+1.
  - A even: A←A>>1.
  - B even: B←B>>1.
  - Both odd, A>B: A←(A−B)>>1.
  - Both odd, B>A: B←(B−A)>>1.
- k width is clog2(WIDTH)+1. All subtraction is unsigned and never underflows, because the smaller operand is always subtracted from the larger.
- DONE: hold `gcd_out` and `iter_out`. On `out_ready` go to IDLE. `in_ready` stays low in DONE, so no new transaction can be accepted in the same cycle a result is popped.
- `in_valid` is ignored outside IDLE. Operand changes during CALC have no effect.
- Asynchronous reset mid-CALC or mid-DONE aborts the transaction immediately. No result is ever presented for the aborted transaction.

## Timing
- Accept edge t0. For nonzero operands the engine needs N steps plus 1 equality cycle. `out_valid` rises after edge t0+N+1, and `iter_out`=N+1.
- For a zero operand, `out_valid` rises after edge t0+1.
- With `out_ready` held high, DONE lasts exactly one cycle. `in_ready` is back high one cycle after the pop edge.
- Worst case:
  - Subtraction: 2^WIDTH−1 cycles, e.g. gcd(2^WIDTH−1, 1). The counter saturates; the result is still correct.
  - Binary: ≤ 2·WIDTH+1 cycles.
- No combinational path from inputs to outputs. `in_ready` and `out_valid` decode from registered state only.

## Structure
- Package `gcd_pkg` holds:
  - the state enum (IDLE, CALC, DONE);
  - the mode constants MODE_SUB=0 and MODE_BIN=1;
  - a k-width function of WIDTH.
- One sub-module, `gcd_datapath`, is natural. It holds the A, B and k registers and the step logic, controlled by load/step/mode signals, and returns eq/A-even/B-even/gt flags.
- The top level `gcd_unit` holds the FSM, iteration counter and output registers.

## Test plan
- Subtraction mode, WIDTH=16: A=143, B=78, mode 0 → `gcd_out`=13, `iter_out`=7, `out_valid` 7 clocks after accept.
- Binary mode: A=48, B=18, mode 1 → `gcd_out`=6, `iter_out`=6.
- Binary mode: A=143, B=78 → `gcd_out`=13, `iter_out`=6.
- Zero operands:
  - (0,35) → 35 with `iter_out`=0, one clock after accept.
  - (0,0) → 0.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`; toggle `in_valid` with new operands meanwhile.
  - Required: result stable, `in_ready`=0 and no second accept.
  - After `out_ready` pulses, the next pair (84,36, mode 1) gives 12.
- Reset and saturation:
  - Assert `rst_n`=0 mid-CALC of (65535,1, mode 0) → all outputs return to reset values asynchronously. The next transaction (100,75, mode 0) gives 25.
  - With CNT_W=4, (200,1, mode 0) → `iter_out`=15 (saturated) and `gcd_out`=1.
